cbm2_memresp: RTL
=================

Name: cbm2_memresp

Overview:
- Responder side of the system bus.
- Accepts a RAM access strobed by the bus decoder (address, chip select, write enable, write data) and runs it on a request/acknowledge external-memory port.
- Returns read data on ramData and a ready flag to the bus.
- Also merges the ROM/RAM download write stream into the same memory port. Bus accesses always take priority.

Parameters:
ADDR_W, 25, width of system and memory address
DATA_W, 8, data width

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
cycle_start  in  1  one-clk pulse at start of each CPU/video bus cycle
cs_ram  in  1  RAM selected for this cycle; sampled with cycle_start
systemAddr  in  ADDR_W  bus address; sampled with cycle_start
systemWe  in  1  write enable; sampled with cycle_start
cpuDo  in  DATA_W  write data; sampled with cycle_start
ramData  out  DATA_W  read data to bus (held)
ram_ready  out  1  high when no bus access is outstanding
dl_wr  in  1  one-clk download write strobe
dl_addr  in  ADDR_W  download address
dl_data  in  DATA_W  download data
dl_busy  out  1  download slot occupied; dl_wr ignored while high
err_ovf  out  1  sticky overflow flag (dropped request)
mem_req  out  1  memory request (level)
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write
mem_din  out  DATA_W  write data to memory
mem_dout  in  DATA_W  read data from memory; valid with mem_ack
mem_ack  in  1  one-clk completion pulse

Behaviour:
- Reset state: all outputs are 0 except ram_ready=1, which is asserted immediately while reset is high.
- After reset, all state is IDLE and both request slots are empty.
- An abandoned memory request is dropped. The memory controller must tolerate mem_req falling before mem_ack.
- Request capture:
  - cycle_start=1 with cs_ram=1 loads the bus slot {addr, we, data}.
  - ram_ready goes 0 on the next clk.
  - cycle_start with cs_ram=0 does nothing; ramData is unchanged.
- Download capture: dl_wr=1 with dl_busy=0 loads the download slot; dl_busy goes 1 on the next clk.
- Dropped requests:
  - dl_wr while dl_busy=1 is dropped and sets err_ovf.
  - cycle_start+cs_ram while the bus slot is already full overwrites the slot and sets err_ovf.
- FSM states: IDLE, BUS_ACC, DL_ACC.
- IDLE:
  - Bus slot full goes to BUS_ACC; otherwise download slot full goes to DL_ACC.
  - A slot loaded in cycle N is issued from IDLE in cycle N+1, with mem_req=1 registered in that cycle.
  - Simultaneous cycle_start and dl_wr: both are captured and the bus is served first.
- BUS_ACC:
  - mem_req=1, with mem_addr/mem_we/mem_din taken from the bus slot and held stable until mem_ack.
  - On mem_ack: a read latches ramData<=mem_dout; a write sets ramData<=cpuDo from the slot.
  - Then the bus slot is cleared, ram_ready=1 on the next clk, mem_req drops, and the FSM returns to IDLE.
- DL_ACC:
  - Same handshake with mem_we=1 and the download slot.
  - On mem_ack: the download slot is cleared, dl_busy=0 on the next clk, and the FSM returns to IDLE.
  - ramData is not changed by download accesses.
- A bus request arriving during DL_ACC waits in its slot and is issued in the cycle after the DL ack. It is never preempted or aborted.
- mem_ack in the same cycle that mem_req rises is legal.
  - Minimum bus latency: cycle_start at N gives ram_ready=1 and ramData valid at N+2.
- mem_ack while in IDLE is ignored.
- Back-to-back accesses: mem_req drops for at least one clk between accesses (through IDLE).
- Address and data are passed unchanged at full ADDR_W width; no arithmetic is performed.

Decomposition:
- Package cbm2_mem_pkg:
  - state enum (IDLE, BUS_ACC, DL_ACC);
  - ADDR_W/DATA_W defaults;
  - packed struct mem_req_t {addr, we, data}.
- Sub-module cbm2_req_slot: single-entry holding register with load/clear/full/overflow. It is instantiated twice, for the bus slot and the download slot.

Test Plan:
- Bus read: cycle_start, cs_ram=1, addr=0x0F1234, we=0; memory acks 3 clks after mem_req with 0xA5 -> mem_addr=0x0F1234, mem_we=0, ramData=0xA5, ram_ready low for exactly 4 clks from cycle_start.
- Bus write: addr=0x001000, we=1, cpuDo=0x3C; immediate ack -> mem_we=1, mem_din=0x3C, ramData=0x3C and ram_ready=1 two clks after cycle_start.
- Simultaneous dl_wr(0x100000,0x11) and bus read(0x000002) -> bus access issued first; download issued in the clk after the bus ack; dl_busy falls after its ack; err_ovf=0.
- Bus request during a download holding mem_ack off for 10 clks -> download completes, then bus access is issued next clk; mem_addr never changes while mem_req=1.
- dl_wr while dl_busy=1, and two cycle_starts with cs_ram=1 before the first ack -> err_ovf=1 and stays set; only the second bus address reaches memory.
- Assert reset during BUS_ACC -> mem_req=0 and ram_ready=1 immediately; after release, a new read completes normally and a stale mem_ack is ignored.

Source files
------------

// File: rtl/cbm2_mem_pkg.sv
// Shared types for the bus-side memory responder: FSM states, default widths
// and the request record held in each pending slot.
// No logic here; imported by every other file of the block.
package cbm2_mem_pkg;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_ACC = 2'd1,
    DL_ACC  = 2'd2
  } state_t;

  // One pending memory access: address, write flag, write data.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  we;
    logic [DATA_W_DEF-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/cbm2_memresp_if.sv
// Request/acknowledge external-memory port.
// Level mem_req with address/data held until a one-clk mem_ack.
// The requester may drop mem_req before mem_ack to abandon an access.
interface cbm2_memresp_if
  import cbm2_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ack;

  modport master (
    output mem_req, mem_addr, mem_we, mem_din,
    input  mem_dout, mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_din,
    output mem_dout, mem_ack
  );

endinterface

// File: rtl/cbm2_req_slot.sv
// Single-entry request holding register with load, clear and overflow report.
// Latency: content and full flag valid the clk after push.
// Push while full either overwrites (OVERWRITE=1) or is dropped; both raise ovf.
module cbm2_req_slot
  import cbm2_mem_pkg::*;
#(
  parameter bit OVERWRITE = 1'b1
) (
  input  logic     clk_sys,
  input  logic     reset,
  input  logic     push,
  input  logic     clear,
  input  mem_req_t din,
  output mem_req_t q,
  output logic     full,
  output logic     ovf
);

  logic take;

  assign take = push & (OVERWRITE | ~full);
  assign ovf  = push & full;

  // A new entry beats a same-cycle clear so a request arriving on the ack clk is kept.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (take) begin
      q    <= din;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cbm2_memresp.sv
// Bus responder: runs captured bus RAM accesses and download writes on one memory port.
// Latency: cycle_start at N -> mem_req at N+1; with same-clk ack, ram_ready/ramData at N+2.
// Bus slot has priority; a bus re-strobe while pending abandons and reissues the access.
module cbm2_memresp
  import cbm2_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cycle_start,
  input  logic              cs_ram,
  input  logic [ADDR_W-1:0] systemAddr,
  input  logic              systemWe,
  input  logic [DATA_W-1:0] cpuDo,
  output logic [DATA_W-1:0] ramData,
  output logic              ram_ready,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_busy,
  output logic              err_ovf,
  cbm2_memresp_if.master    mem
);

  state_t   state, stateNxt;
  mem_req_t busIn, dlIn, busQ, dlQ;
  logic     busPush, busFull, busOvf, busAck;
  logic     dlFull, dlOvf, dlAck;

  assign busPush = cycle_start & cs_ram;
  assign busIn   = '{addr: systemAddr, we: systemWe, data: cpuDo};
  assign dlIn    = '{addr: dl_addr, we: 1'b1, data: dl_data};
  assign busAck  = (state == BUS_ACC) & mem.mem_ack;
  assign dlAck   = (state == DL_ACC) & mem.mem_ack;

  cbm2_req_slot #(.OVERWRITE(1'b1)) busSlot (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (busPush),
    .clear   (busAck),
    .din     (busIn),
    .q       (busQ),
    .full    (busFull),
    .ovf     (busOvf)
  );

  cbm2_req_slot #(.OVERWRITE(1'b0)) dlSlot (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (dl_wr),
    .clear   (dlAck),
    .din     (dlIn),
    .q       (dlQ),
    .full    (dlFull),
    .ovf     (dlOvf)
  );

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNxt;
  end

  // Next state: IDLE also looks at same-clk captures so an access starts the clk after its strobe.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (busPush || busFull)    stateNxt = BUS_ACC;
        else if (dl_wr || dlFull)  stateNxt = DL_ACC;
      end
      BUS_ACC: begin
        // A re-strobe replaces the slot; drop mem_req so the new address is issued cleanly.
        if (mem.mem_ack || busPush) stateNxt = IDLE;
      end
      DL_ACC: begin
        if (mem.mem_ack) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Memory port driven straight from state and slot registers, so it is glitch-free and stable.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_addr = '0;
    mem.mem_we   = 1'b0;
    mem.mem_din  = '0;
    case (state)
      BUS_ACC: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = busQ.addr;
        mem.mem_we   = busQ.we;
        mem.mem_din  = busQ.data;
      end
      DL_ACC: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = dlQ.addr;
        mem.mem_we   = dlQ.we;
        mem.mem_din  = dlQ.data;
      end
      default: ;
    endcase
  end

  // Bus result: read data from memory, or echo the written byte.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)       ramData <= '0;
    else if (busAck) ramData <= busQ.we ? busQ.data : mem.mem_dout;
  end

  // Sticky record of any dropped or overwritten request; only reset clears it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                err_ovf <= 1'b0;
    else if (busOvf || dlOvf) err_ovf <= 1'b1;
  end

  assign ram_ready = ~busFull;
  assign dl_busy   = dlFull;

endmodule
